// File: rtl/bin_to_bcd4_if.sv
// Handshake and result bundle between an upstream value source and bin_to_bcd4.
// The master drives the value side; the slave (the converter) drives the result side.
interface bin_to_bcd4_if #(
    parameter int IN_WIDTH = 16
);
    // Input handshake: a value transfers at a rising edge where in_valid and in_ready
    // are both high. The source keeps in_valid and in_data steady until that edge.
    // out_valid is a single-cycle pulse with no back-pressure.
    logic [IN_WIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         bcd;
    logic [3:0]          blank;
    logic                overflow;
    logic                out_valid;
    logic                busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, bcd, blank, overflow, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bcd, blank, overflow, out_valid, busy
    );
endinterface

// File: rtl/bin_to_bcd4.sv
// Iterative double-dabble binary-to-BCD converter feeding a 4-digit display.
// Results are registered only at the end of a conversion, so the display never sees partial values.
module bin_to_bcd4 #(
    parameter int IN_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    bin_to_bcd4_if.slave   bus,
    output logic [1:0]     dbg_state
);
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [IN_WIDTH-1:0] sr;
    logic [19:0]         acc;
    logic [19:0]         acc_adj;

    // Add 3 to each digit of 5 or more, so the following shift carries correctly into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < 5; d++) begin
            if (acc[d*4 +: 4] >= 4'd5) begin
                acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            sr            <= '0;
            acc           <= '0;
            bus.bcd       <= 16'h0000;
            bus.blank     <= 4'b1110;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr           <= bus.in_data;
                        acc          <= '0;
                        count        <= CW'(IN_WIDTH - 1);
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {acc_adj[18:0], sr[IN_WIDTH-1]};
                    sr  <= {sr[IN_WIDTH-2:0], 1'b0};
                    if (count == '0) begin
                        state <= LOAD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                LOAD: begin
                    bus.bcd       <= acc[15:0];
                    bus.overflow  <= (acc[19:16] != 4'd0);
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    // An overflowed value has a non-zero fifth digit, so nothing shown is leading.
                    if (acc[19:16] != 4'd0) begin
                        bus.blank <= 4'b0000;
                    end else begin
                        bus.blank[3] <= (acc[15:12] == 4'd0);
                        bus.blank[2] <= (acc[15:8]  == 8'd0);
                        bus.blank[1] <= (acc[15:4]  == 12'd0);
                        bus.blank[0] <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd4.sv
// Bench for bin_to_bcd4: directed corner values, back-to-back handshake, mid-conversion
// reset and random values, scored against an arithmetic decimal model.
module tb_bin_to_bcd4;
    localparam int IN_WIDTH = 16;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_err    = 0;
    int         ov_cnt   = 0;
    logic [20:0] exp_q[$];

    bin_to_bcd4_if #(.IN_WIDTH(IN_WIDTH)) bus_if ();

    bin_to_bcd4 #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, {overflow, blank, bcd}
    function automatic logic [20:0] model(input int v);
        logic [15:0] b;
        logic [3:0]  bl;
        logic        ov;
        b  = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        ov = (v > 9999);
        if (ov) bl = 4'b0000;
        else    bl = {(v < 1000), (v < 100), (v < 10), 1'b0};
        return {ov, bl, b};
    endfunction

    // Scoreboard: push on accept, pop on out_valid
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.out_valid) begin
                ov_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("result", {11'd0, bus_if.overflow, bus_if.blank, bus_if.bcd}, {11'd0, exp_q.pop_front()});
                end
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                exp_q.push_back(model(int'(bus_if.in_data)));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_bcd"},      {16'd0, bus_if.bcd},   32'h0000);
        check({tag, "_blank"},    {28'd0, bus_if.blank}, 32'b1110);
        check({tag, "_overflow"}, {31'd0, bus_if.overflow},  32'd0);
        check({tag, "_out_valid"},{31'd0, bus_if.out_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, bus_if.in_ready},  32'd1);
        check({tag, "_busy"},     {31'd0, bus_if.busy},      32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus_if.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.in_ready) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    // Driver: one conversion, returns edges from accept to out_valid and busy cycle count
    task automatic do_conv(input int v, output int lat, output int busy_cyc);
        @(negedge clk);
        wait_ready();
        bus_if.in_data  = IN_WIDTH'(v);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        busy_cyc = 0;
        if (bus_if.busy) busy_cyc++;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus_if.out_valid) break;
            if (bus_if.busy) busy_cyc++;
        end
        if (!bus_if.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, bc, v, base;
        int dir_vals[6] = '{1234, 0, 7, 9999, 10000, 65535};
        rst_n = 1'b1;
        bus_if.in_data  = '0;
        bus_if.in_valid = 1'b0;

        // Asynchronous reset applied between edges
        #3 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal conversion with latency and busy length
        do_conv(1234, lat, bc);
        check("latency_1234", 32'(lat), 32'(IN_WIDTH + 1));
        check("busy_cycles_1234", 32'(bc), 32'(IN_WIDTH + 1));
        @(posedge clk); #1;
        check("out_valid_single", {31'd0, bus_if.out_valid}, 32'd0);

        // Corner values
        for (int i = 1; i < 6; i++) begin
            do_conv(dir_vals[i], lat, bc);
            check("latency_dir", 32'(lat), 32'(IN_WIDTH + 1));
        end

        // Back-to-back with held in_valid and an ignored pulse while busy
        @(negedge clk);
        wait_ready();
        bus_if.in_data  = 16'd42;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_data = 16'd305;
        repeat (4) @(posedge clk);
        #1 bus_if.in_data = 16'd777;
        @(posedge clk); #1;
        bus_if.in_data = 16'd305;
        lat = 0;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
        @(posedge clk); #1;
        check("b2b_second_captured", {31'd0, bus_if.busy}, 32'd1);
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'(IN_WIDTH + 1));

        // Reset mid-conversion discards the result
        @(negedge clk);
        wait_ready();
        bus_if.in_data  = 16'd4321;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_values("midreset");
        base = ov_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (IN_WIDTH + 4) @(posedge clk);
        #1 check("midreset_no_out_valid", 32'(ov_cnt), 32'(base));
        check("midreset_bcd_held", {16'd0, bus_if.bcd}, 32'h0000);
        do_conv(56, lat, bc);
        check("after_reset_latency", 32'(lat), 32'(IN_WIDTH + 1));

        // Random values
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(0, 65535);
            do_conv(v, lat, bc);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bin_to_bcd4.md
# bin_to_bcd4

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit multiplexed seven-segment driver. It accepts an unsigned binary value, such as a CPU register or bus value, through a valid/ready handshake. It converts the value with an iterative shift-add-3 (double-dabble) datapath and holds the 4-digit packed BCD result stable for the display. It also produces a leading-zero blanking mask and an overflow flag for values above 9999.

## Interface
- IN_WIDTH, 16: width of the binary input; legal range 4..16. The internal accumulator is always 5 BCD digits (20 bits).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_data  in  IN_WIDTH  unsigned binary value to convert.
- in_valid  in  1  in_data is presented for conversion.
- in_ready  out  1  block can accept a value; high only in IDLE.
- bcd  out  16  packed BCD result: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands. Feeds the display driver's 16-bit value input.
- blank  out  4  per-digit leading-zero blank mask, same digit order as bcd; 1 = digit is a leading zero.
- overflow  out  1  last converted value exceeded 9999.
- out_valid  out  1  one-cycle pulse; bcd, blank and overflow were just updated.
- busy  out  1  conversion in progress (state SHIFT or LOAD).

## Operation
- States:
  - IDLE: in_ready=1. If in_valid is high at a rising edge, capture in_data into the shift register, clear the 20-bit BCD accumulator, set the bit counter to IN_WIDTH-1, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator digit that is ≥5, then shift {accumulator, shift register} left by 1. When the counter is 0, go to LOAD; otherwise decrement the counter.
  - LOAD: register the outputs from the accumulator and go to IDLE.
- LOAD output rules:
  - bcd = accumulator[15:0], i.e. the lower 4 digits, result mod 10000.
  - overflow = (accumulator digit 4 != 0).
  - blank: if overflow=1, blank=4'b0000. Otherwise blank[k]=1 when digit k and all higher digits are 0, for k=3..1. blank[0] is always 0, so value 0 shows a single "0".
- Output registers are written only in LOAD. bcd, blank and overflow hold their last values through any number of later IDLE and SHIFT cycles, so the display never shows an intermediate value.
- in_valid is ignored while busy. There is no queueing; the value is simply not captured, and an upstream source must hold in_valid until it sees in_ready.
- Input bits above IN_WIDTH do not exist. With IN_WIDTH<14 the overflow flag cannot assert.
- Accumulator width rule: 5 digits cover the maximum 65535. Every digit after add-3 is ≤12 before the shift, so there is no carry out of the 20 bits.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, bcd=16'h0000, blank=4'b1110, overflow=0, out_valid=0, busy=0, in_ready=1.
  - Counter, shift register and accumulator are cleared.
- Reset takes effect immediately, mid-conversion included. The conversion is discarded, outputs return to reset values, and no out_valid is produced.
- Latency, with the accept edge as E0:
  - Edges E1..E_IN_WIDTH perform the shifts; the state enters LOAD after E_IN_WIDTH.
  - At E_IN_WIDTH+1 the outputs update and out_valid goes high for exactly one cycle. For IN_WIDTH=16 this is E17.
- busy is high from after E0 until E_IN_WIDTH+1; in_ready = ~busy.
- The cycle in which out_valid is high is an IDLE cycle, so a new value can be accepted at the same edge that ends the pulse. Maximum throughput is one conversion per IN_WIDTH+2 cycles.
- The outputs are registers with no combinational path from the inputs.

## Test plan
- Reset: assert rst_n=0 mid-cycle. Required: bcd=0x0000, blank=1110, overflow=0, out_valid=0, in_ready=1, with no clock edge needed.
- Normal conversion: in_data=1234 accepted at E0. Required: out_valid at E17 only; bcd=0x1234, blank=0000, overflow=0; busy high for exactly 17 cycles.
- Leading zeros: in_data=0 gives bcd=0x0000, blank=1110. in_data=7 gives bcd=0x0007, blank=1110. in_data=9999 gives bcd=0x9999, blank=0000, overflow=0.
- Overflow boundary: in_data=10000 gives bcd=0x0000, overflow=1, blank=0000. in_data=65535 gives bcd=0x5535, overflow=1.
- Back-to-back and ignore: hold in_valid high with 42, then 305.
  - The second value must be captured at the out_valid edge: results 0x0042/blank 1100, then 0x0305/blank 1000.
  - A different in_data pulsed while busy must not change either result.
- Reset mid-conversion: accept 4321, drop rst_n at cycle 8, release. Required: no out_valid; outputs at reset values; a following conversion of 56 gives 0x0056.
